// File: rtl/sort_result_streamer.sv
// rtl/sort_result_streamer.sv - streams the sorted RAM contents out on valid/ready
// Optional order checker enabled by defining ORDER_CHECK_EN.
module sort_result_streamer #(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_DATA = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_num_elems,
  output logic                 o_rd_en,
  output logic [SIZE_ADDR-1:0] o_addr,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_order_err
);

  localparam int CW = SIZE_ADDR + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        n_reg;
  logic [CW-1:0]        rd_cnt;
  logic [CW-1:0]        out_idx;
  logic                 inflight;
  logic [SIZE_DATA-1:0] fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           occ;
  logic [2:0]           pending;
  logic                 push;
  logic                 pop;
  logic                 rd_issue;

  assign o_valid = (occ != 2'd0);
  assign o_data  = fifo_mem[rd_ptr];
  assign o_last  = o_valid && (out_idx == (n_reg - CW'(1)));
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);

  assign push    = inflight;
  assign pop     = o_valid & i_ready;

  // A read is only issued if its data is guaranteed a FIFO slot on arrival.
  assign pending  = {1'b0, occ} + {2'b00, inflight};
  assign rd_issue = (state == STREAM) && (rd_cnt < n_reg) &&
                    (pending < (3'd2 + {2'b00, pop}));
  assign o_rd_en  = rd_issue;
  assign o_addr   = rd_issue ? rd_cnt[SIZE_ADDR-1:0] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      n_reg    <= '0;
      rd_cnt   <= '0;
      out_idx  <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      inflight <= rd_issue;
      if (rd_issue) rd_cnt <= rd_cnt + CW'(1);
      if (push) begin
        fifo_mem[wr_ptr] <= i_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        out_idx <= out_idx + CW'(1);
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (i_start) begin
            n_reg   <= {1'b0, i_num_elems};
            rd_cnt  <= '0;
            out_idx <= '0;
            state   <= (i_num_elems == '0) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (pop && o_last) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ORDER_CHECK_EN
  logic [SIZE_DATA-1:0] prev_data;
  logic                 have_prev;
  logic                 order_err;

  // Each accepted element is compared to the one accepted before it in the same run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_data <= '0;
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if ((state == IDLE) && i_start) begin
      have_prev <= 1'b0;
      order_err <= 1'b0;
    end else if (pop) begin
      if (have_prev && (o_data < prev_data)) order_err <= 1'b1;
      prev_data <= o_data;
      have_prev <= 1'b1;
    end
  end

  assign o_order_err = order_err;
`else
  assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_streamer.sv
// tb/tb_sort_result_streamer.sv - scoreboard bench for sort_result_streamer
module tb_sort_result_streamer;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic [7:0] i_num_elems;
  logic       o_rd_en;
  logic [7:0] o_addr;
  logic [7:0] i_data = 8'h00;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_last;
  logic       o_busy;
  logic       o_done;
  logic       o_order_err;

  sort_result_streamer #(.SIZE_ADDR(8), .SIZE_DATA(8)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_elems(i_num_elems),
    .o_rd_en(o_rd_en), .o_addr(o_addr), .i_data(i_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_last(o_last), .o_busy(o_busy),
    .o_done(o_done), .o_order_err(o_order_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [256];
  always @(posedge clk) if (o_rd_en) i_data <= ram[o_addr];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  logic [8:0] exp_q [$];
  int rd_cyc [$];
  int rd_addr [$];
  int hs_cyc [$];
  int hs_err [$];
  int done_cyc [$];
  int busy_cyc [$];
  int out_cnt = 0;
  int max_out = 0;
  bit stall_pending = 0;
  logic [7:0] held = 8'h00;

  bit ready_mode = 0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_ready = ready_mode ? pat[(cyc - t0) & 3] : 1'b1;
    end
  end

  // Monitor: logs events and pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (!i_rst_n) begin
      stall_pending = 0;
    end else begin
      if (stall_pending) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, held);
      end
      stall_pending = o_valid && !i_ready;
      held = o_data;
      if (o_rd_en) begin
        rd_cyc.push_back(cyc - t0);
        rd_addr.push_back(o_addr);
        out_cnt++;
      end
      if (o_valid && i_ready) begin
        hs_cyc.push_back(cyc - t0);
        hs_err.push_back(o_order_err);
        out_cnt--;
        if (exp_q.size() == 0) begin
          chk("unexpected_elem", o_data, 999);
        end else begin
          chk("elem_last_data", {o_last, o_data}, exp_q.pop_front());
        end
      end
      if (out_cnt > max_out) max_out = out_cnt;
      if (o_done) done_cyc.push_back(cyc - t0);
      if (o_busy) busy_cyc.push_back(cyc - t0);
    end
  end

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete(); hs_cyc.delete(); hs_err.delete();
    done_cyc.delete(); busy_cyc.delete(); exp_q.delete();
    out_cnt = 0; max_out = 0;
  endtask

  task automatic start_run(input int n);
    @(posedge clk);
    #1;
    i_num_elems = n[7:0];
    i_start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    bit seen = 0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    chk("done_seen", seen, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_num_elems = 8'd0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {o_rd_en, o_addr, o_valid, o_data, o_last, o_busy, o_done, o_order_err}, 0);
    @(posedge clk);
    #1 i_rst_n = 1'b1;

    // Ascending data, ready held high: exact timing.
    for (int i = 0; i < 4; i++) ram[i] = 8'(i + 1);
    clear_logs();
    for (int i = 0; i < 4; i++) push_exp(8'(i + 1), i == 3);
    start_run(4);
    wait_done(30);
    chk("t1_rd_count", rd_cyc.size(), 4);
    for (int i = 0; i < 4 && i < rd_cyc.size(); i++) begin
      chk("t1_rd_cycle", rd_cyc[i], i + 1);
      chk("t1_rd_addr", rd_addr[i], i);
    end
    chk("t1_hs_count", hs_cyc.size(), 4);
    for (int i = 0; i < 4 && i < hs_cyc.size(); i++) chk("t1_hs_cycle", hs_cyc[i], i + 3);
    chk("t1_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("t1_done_cycle", done_cyc[0], 7);
    chk("t1_order_err", o_order_err, 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // Same data with back-pressure.
    clear_logs();
    for (int i = 0; i < 4; i++) push_exp(8'(i + 1), i == 3);
    ready_mode = 1;
    start_run(4);
    wait_done(60);
    ready_mode = 0;
    chk("t2_hs_count", hs_cyc.size(), 4);
    chk("t2_rd_count", rd_cyc.size(), 4);
    for (int i = 0; i < 4 && i < rd_addr.size(); i++) chk("t2_rd_addr", rd_addr[i], i);
    chk("t2_credit_ok", max_out <= 2, 1);
    chk("t2_done_count", done_cyc.size(), 1);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Out-of-order data.
    ram[0] = 8'h05; ram[1] = 8'h03; ram[2] = 8'h07; ram[3] = 8'h07;
    clear_logs();
    push_exp(8'h05, 0); push_exp(8'h03, 0); push_exp(8'h07, 0); push_exp(8'h07, 1);
    start_run(4);
    wait_done(30);
    chk("t3_hs_count", hs_cyc.size(), 4);
`ifdef ORDER_CHECK_EN
    for (int i = 0; i < 4 && i < hs_err.size(); i++) chk("t3_err_at_hs", hs_err[i], (i >= 2) ? 1 : 0);
    chk("t3_err_after_done", o_order_err, 1);
`else
    for (int i = 0; i < 4 && i < hs_err.size(); i++) chk("t3_err_at_hs", hs_err[i], 0);
    chk("t3_err_after_done", o_order_err, 0);
`endif
    chk("t3_sb_empty", exp_q.size(), 0);

    // Empty run.
    clear_logs();
    start_run(0);
    repeat (5) @(posedge clk);
    chk("t4_rd_count", rd_cyc.size(), 0);
    chk("t4_hs_count", hs_cyc.size(), 0);
    chk("t4_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("t4_done_cycle", done_cyc[0], 1);
    chk("t4_busy_count", busy_cyc.size(), 1);
    if (busy_cyc.size() > 0) chk("t4_busy_cycle", busy_cyc[0], 1);
    chk("t4_err_cleared", o_order_err, 0);

    // Reset in the middle of a 10-element run, then restart.
    for (int i = 0; i < 10; i++) ram[i] = 8'(8'h10 + i);
    clear_logs();
    push_exp(8'h10, 0); push_exp(8'h11, 0);
    start_run(10);
    repeat (4) @(posedge clk);
    #1 i_rst_n = 1'b0;
    @(negedge clk);
    chk("t5_reset_outputs", {o_rd_en, o_addr, o_valid, o_data, o_last, o_busy, o_done, o_order_err}, 0);
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("t5_hs_count", hs_cyc.size(), 2);
    chk("t5_no_done", done_cyc.size(), 0);
    chk("t5_sb_empty", exp_q.size(), 0);
    clear_logs();
    push_exp(8'h10, 0); push_exp(8'h11, 0); push_exp(8'h12, 1);
    start_run(3);
    wait_done(30);
    chk("t5r_rd_count", rd_cyc.size(), 3);
    for (int i = 0; i < 3 && i < rd_addr.size(); i++) chk("t5r_rd_addr", rd_addr[i], i);
    chk("t5r_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("t5r_done_cycle", done_cyc[0], 6);
    chk("t5r_sb_empty", exp_q.size(), 0);

    // Extra start pulses during STREAM and during DONE are ignored.
    for (int i = 0; i < 4; i++) ram[i] = 8'(i + 1);
    clear_logs();
    for (int i = 0; i < 4; i++) push_exp(8'(i + 1), i == 3);
    start_run(4);
    repeat (2) @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (10) @(posedge clk);
    chk("t6_rd_count", rd_cyc.size(), 4);
    chk("t6_hs_count", hs_cyc.size(), 4);
    chk("t6_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("t6_done_cycle", done_cyc[0], 7);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_result_streamer.md
Name: sort_result_streamer

Overview:
- Downstream stage of the selection sorter.
- When started, typically by the sorter's done pulse, it reads the sorted array out of the shared single-port RAM at addresses 0..N-1.
- It streams the elements on a valid/ready interface and optionally checks that they are in non-decreasing order.
- It owns the RAM read port only while busy; the top level muxes the RAM port between the sorter and this block.

Parameters:
- SIZE_ADDR, 8, RAM address width; also the width of the element count.
- SIZE_DATA, 8, RAM data width and output data width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle start pulse.
- i_num_elems  in  SIZE_ADDR  element count N; latched when i_start is accepted.
- o_rd_en  out  1  RAM read enable.
- o_addr  out  SIZE_ADDR  RAM read address.
- i_data  in  SIZE_DATA  RAM read data; valid in the cycle after o_rd_en.
- o_valid  out  1  output element valid.
- i_ready  in  1  consumer ready.
- o_data  out  SIZE_DATA  output element.
- o_last  out  1  qualifies the final element (index N-1).
- o_busy  out  1  high while streaming.
- o_done  out  1  one-cycle completion pulse.
- o_order_err  out  1  sticky flag: an element was less than its predecessor.

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE; all outputs 0; buffer emptied; counters 0.
  - Any in-flight RAM read is discarded. Reset mid-stream aborts with no o_done.
- FSM states: IDLE, STREAM, DONE.
  - IDLE -> STREAM on i_start when N>0. N and the read address (set to 0) are latched.
  - IDLE -> DONE on i_start when N==0. No reads are issued and o_valid never rises.
  - STREAM -> DONE on the handshake (o_valid & i_ready) of the element with o_last=1.
  - DONE -> IDLE unconditionally after one cycle. o_done=1 only in DONE.
- i_start is ignored in STREAM and DONE.
- o_busy=1 in STREAM and DONE.
- Read issue:
  - In STREAM, assert o_rd_en with o_addr=read counter when read counter < N and (buffer occupancy + reads in flight - pop this cycle) < 2.
  - The read counter increments on each issued read.
  - o_rd_en stays 0 outside STREAM.
- Buffer:
  - 2-entry FIFO. The i_data captured at the end of the cycle after a read becomes a FIFO entry.
  - o_valid = FIFO non-empty; o_data = head entry.
  - o_data and o_valid hold stable while o_valid & !i_ready; no element is dropped or duplicated.
- Timing with i_ready held high:
  - i_start is high in cycle 0. Cycle 1: o_rd_en=1, o_addr=0. Cycle 2: i_data captured. Cycle 3: first o_valid.
  - From then on, one element per cycle. The last element is in cycle N+2; o_done is in cycle N+3.
- o_last = o_valid & (output index == N-1). The output index is a separate counter, incremented per handshake.
- Counter widths:
  - Counters are SIZE_ADDR+1 bits so that N = 2^SIZE_ADDR-1 terminates without wrap.
  - The address driven is the low SIZE_ADDR bits.
- Order check:
  - Compare each handshaked element against the previously handshaked element, as unsigned values. The first element of a run is not compared.
  - If current < previous, set o_order_err. Equal values are legal.
  - o_order_err clears on an accepted i_start or on reset, and otherwise holds through DONE and IDLE.
- Simultaneous events:
  - A pop and a capture in the same cycle leave occupancy unchanged.
  - i_start coinciding with DONE is ignored.

Optional Feature:
- Macro ORDER_CHECK_EN.
- Defined: the order checker, previous-element register and o_order_err behave as above.
- Undefined: the checker logic is absent and o_order_err is tied to 0.
- Streaming behaviour is identical in both builds.

Test Plan:
- RAM preloaded 01,02,03,04; N=4; i_ready=1; pulse i_start:
  - o_rd_en in cycles 1-4 at addresses 0-3.
  - o_valid in cycles 3-6 with data 01..04; o_last only in cycle 6; o_done in cycle 7.
  - o_order_err=0.
- Same RAM, i_ready toggling 1,0,0,1,...:
  - Data order 01..04 with no loss or duplication; o_data stable while stalled.
  - o_rd_en never issues beyond buffer credit (occupancy + in-flight ≤ 2).
- RAM 05,03,07,07; N=4:
  - With ORDER_CHECK_EN, o_order_err rises on the handshake of 03 and stays high after o_done.
  - Without ORDER_CHECK_EN, o_order_err stays 0.
- N=0, pulse i_start: no o_rd_en, no o_valid; o_done=1 in cycle 1; o_busy=1 in cycle 1 only.
- Reset mid-stream: N=10 with i_ready=1; assert i_rst_n=0 in cycle 5:
  - All outputs go to 0 immediately; no o_done.
  - A subsequent i_start restarts from address 0.
- i_start pulsed again during STREAM (N=4): ignored; exactly 4 elements are streamed and a single o_done follows.
